// File: rtl/gpr_pkg.sv
// Shared definitions for the general purpose register bank sequencer:
// default sizes, register indices and the decoded micro-op record.
package gpr_pkg;

    localparam int GPR_NUM_REGS = 4;
    localparam int GPR_SEL_W    = 2;

    localparam logic [GPR_SEL_W-1:0] REG_A = 2'd0;
    localparam logic [GPR_SEL_W-1:0] REG_B = 2'd1;
    localparam logic [GPR_SEL_W-1:0] REG_C = 2'd2;
    localparam logic [GPR_SEL_W-1:0] REG_D = 2'd3;

    typedef struct packed {
        logic                 lhs_en;
        logic [GPR_SEL_W-1:0] lhs_sel;
        logic                 rhs_en;
        logic [GPR_SEL_W-1:0] rhs_sel;
        logic                 main_en;
        logic [GPR_SEL_W-1:0] main_sel;
        logic                 dst_en;
        logic [GPR_SEL_W-1:0] dst_sel;
    } uop_t;

endpackage

// File: rtl/gpr_bus_sequencer_if.sv
// Micro-op issue handshake plus the register bank strobe bundle.
// master = issuer / bank side, slave = the sequencer.
interface gpr_bus_sequencer_if
    import gpr_pkg::*;
#(
    parameter int NUM_REGS = GPR_NUM_REGS,
    parameter int SEL_W    = GPR_SEL_W
);
    logic                op_valid;
    logic                op_ready;
    logic                lhs_en;
    logic [SEL_W-1:0]    lhs_sel;
    logic                rhs_en;
    logic [SEL_W-1:0]    rhs_sel;
    logic                main_en;
    logic [SEL_W-1:0]    main_sel;
    logic                dst_en;
    logic [SEL_W-1:0]    dst_sel;
    logic                hold;
    logic                flush;
    logic [NUM_REGS-1:0] a_lhs_n;
    logic [NUM_REGS-1:0] a_rhs_n;
    logic [NUM_REGS-1:0] a_main_n;
    logic [NUM_REGS-1:0] load_n;
    logic                alu_main_oe;
    logic                hazard;

    modport master (
        output op_valid, lhs_en, lhs_sel, rhs_en, rhs_sel,
               main_en, main_sel, dst_en, dst_sel, hold, flush,
        input  op_ready, a_lhs_n, a_rhs_n, a_main_n, load_n,
               alu_main_oe, hazard
    );

    modport slave (
        input  op_valid, lhs_en, lhs_sel, rhs_en, rhs_sel,
               main_en, main_sel, dst_en, dst_sel, hold, flush,
        output op_ready, a_lhs_n, a_rhs_n, a_main_n, load_n,
               alu_main_oe, hazard
    );

endinterface

// File: rtl/gpr_strobe_decode.sv
// Select + enable to active-low one-hot strobe vector.
// Out-of-range selects leave every strobe inactive.
module gpr_strobe_decode
    import gpr_pkg::*;
#(
    parameter int NUM_REGS = GPR_NUM_REGS,
    parameter int SEL_W    = GPR_SEL_W
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] strobe_n
);

    always_comb begin
        strobe_n = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (int'(sel) == i)) begin
                strobe_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpr_bus_sequencer.sv
// Two-stage issue sequencer for the A..D register bank: S1 drives operand and
// move strobes, S2 performs ALU writeback; RAW and MainBus hazards insert bubbles.
module gpr_bus_sequencer
    import gpr_pkg::*;
#(
    parameter int NUM_REGS = GPR_NUM_REGS,
    parameter int SEL_W    = GPR_SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    gpr_bus_sequencer_if.slave bus
);

    uop_t                op_in;
    uop_t                op_p1_q, op_p1_d;
    logic                vld_p1_q, vld_p1_d;
    logic                vld_p2_q, vld_p2_d;
    logic [SEL_W-1:0]    dst_p2_q, dst_p2_d;

    logic [NUM_REGS-1:0] lhs_n_q, lhs_n_d;
    logic [NUM_REGS-1:0] rhs_n_q, rhs_n_d;
    logic [NUM_REGS-1:0] main_n_q, main_n_d;
    logic [NUM_REGS-1:0] load_n_q, load_n_d;
    logic                alu_oe_q, alu_oe_d;

    logic                s1_alu_wr;
    logic                conflict;
    logic                hazard;
    logic                op_ready;
    logic                accept;
    logic                quiet;
    logic                ld_en;
    logic [SEL_W-1:0]    ld_sel;

    always_comb begin
        op_in.lhs_en   = bus.lhs_en;
        op_in.lhs_sel  = bus.lhs_sel;
        op_in.rhs_en   = bus.rhs_en;
        op_in.rhs_sel  = bus.rhs_sel;
        op_in.main_en  = bus.main_en;
        op_in.main_sel = bus.main_sel;
        op_in.dst_en   = bus.dst_en;
        op_in.dst_sel  = bus.dst_sel;
    end

    // Any MainBus use conflicts with an ALU writer in S1, which also covers main_sel == dst.
    always_comb begin
        s1_alu_wr = vld_p1_q && !op_p1_q.main_en && op_p1_q.dst_en;
        conflict  = s1_alu_wr && bus.op_valid &&
                    ((bus.lhs_en && (bus.lhs_sel == op_p1_q.dst_sel)) ||
                     (bus.rhs_en && (bus.rhs_sel == op_p1_q.dst_sel)) ||
                     bus.main_en);
        hazard    = !rst && !bus.hold && !bus.flush && conflict;
        op_ready  = !rst && !bus.hold && !bus.flush && !hazard;
        accept    = bus.op_valid && op_ready;
    end

    // ---- S1 -> S2 stage advance ----
    always_comb begin
        op_p1_d  = op_p1_q;
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        dst_p2_d = dst_p2_q;
        if (bus.flush) begin
            vld_p1_d = 1'b0;
            vld_p2_d = 1'b0;
        end else if (!bus.hold) begin
            vld_p2_d = s1_alu_wr;
            dst_p2_d = op_p1_q.dst_sel;
            vld_p1_d = accept;
            if (accept) begin
                op_p1_d = op_in;
            end
        end
    end

    // Move loads (S1) and ALU loads (S2) never coincide: the hazard blocks MainBus users.
    always_comb begin
        ld_en    = vld_p2_d || (vld_p1_d && op_p1_d.main_en && op_p1_d.dst_en);
        ld_sel   = vld_p2_d ? dst_p2_d : op_p1_d.dst_sel;
        alu_oe_d = vld_p2_d;
    end

    gpr_strobe_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_lhs (
        .en       (vld_p1_d && op_p1_d.lhs_en),
        .sel      (op_p1_d.lhs_sel),
        .strobe_n (lhs_n_d)
    );

    gpr_strobe_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_rhs (
        .en       (vld_p1_d && op_p1_d.rhs_en),
        .sel      (op_p1_d.rhs_sel),
        .strobe_n (rhs_n_d)
    );

    gpr_strobe_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_main (
        .en       (vld_p1_d && op_p1_d.main_en),
        .sel      (op_p1_d.main_sel),
        .strobe_n (main_n_d)
    );

    gpr_strobe_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_load (
        .en       (ld_en),
        .sel      (ld_sel),
        .strobe_n (load_n_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            lhs_n_q  <= '1;
            rhs_n_q  <= '1;
            main_n_q <= '1;
            load_n_q <= '1;
            alu_oe_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            lhs_n_q  <= lhs_n_d;
            rhs_n_q  <= rhs_n_d;
            main_n_q <= main_n_d;
            load_n_q <= load_n_d;
            alu_oe_q <= alu_oe_d;
        end
        op_p1_q  <= op_p1_d;
        dst_p2_q <= dst_p2_d;
    end

    // A held or resetting pipeline must not strobe, or the bank would reload on release.
    assign quiet = rst || bus.hold;

    assign bus.a_lhs_n     = lhs_n_q  | {NUM_REGS{quiet}};
    assign bus.a_rhs_n     = rhs_n_q  | {NUM_REGS{quiet}};
    assign bus.a_main_n    = main_n_q | {NUM_REGS{quiet}};
    assign bus.load_n      = load_n_q | {NUM_REGS{quiet}};
    assign bus.alu_main_oe = alu_oe_q && !quiet;
    assign bus.hazard      = hazard;
    assign bus.op_ready    = op_ready;

    a_lhs_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(~bus.a_lhs_n));
    a_rhs_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(~bus.a_rhs_n));
    a_main_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(~bus.a_main_n));
    a_load_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(~bus.load_n));
    a_main_owner: assert property (@(posedge clk) disable iff (rst)
                                   !(bus.alu_main_oe && (bus.a_main_n != '1)));

endmodule

// File: tb/tb_gpr_bus_sequencer.sv
// Bench for gpr_bus_sequencer: directed vector table, a few multi-cycle sequences,
// then random traffic checked against a cycle-timeline reference model.
module tb_gpr_bus_sequencer;
    import gpr_pkg::*;

    localparam int NR = GPR_NUM_REGS;
    localparam int SW = GPR_SEL_W;
    localparam bit [NR-1:0] F = {NR{1'b1}};
    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;

    typedef struct {
        bit          rst;
        bit          op_valid;
        bit          lhs_en;
        bit [SW-1:0] lhs_sel;
        bit          rhs_en;
        bit [SW-1:0] rhs_sel;
        bit          main_en;
        bit [SW-1:0] main_sel;
        bit          dst_en;
        bit [SW-1:0] dst_sel;
        bit          hold;
        bit          flush;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit [NR-1:0] lhs;
        bit [NR-1:0] rhs;
        bit [NR-1:0] main;
        bit [NR-1:0] load;
        bit          oe;
        bit          haz;
        bit          rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    gpr_bus_sequencer_if #(.NUM_REGS(NR), .SEL_W(SW)) bus ();

    gpr_bus_sequencer #(.NUM_REGS(NR), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    int cyc;
    int loads_seen;

    // Reference timeline: slot k holds the strobes due k active cycles from now.
    bit [NR-1:0] m_lhs [3];
    bit [NR-1:0] m_rhs [3];
    bit [NR-1:0] m_main[3];
    bit [NR-1:0] m_load[3];
    bit          m_oe  [3];
    int          m_wr  [3];

    function automatic bit [NR-1:0] strobe(bit en, int sel);
        bit [NR-1:0] v;
        v = F;
        if (en && sel >= 0 && sel < NR) v[sel] = 1'b0;
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            m_lhs[k] = F; m_rhs[k] = F; m_main[k] = F; m_load[k] = F;
            m_oe[k] = 1'b0; m_wr[k] = -1;
        end
    endfunction

    // An op may not read a register whose ALU write lands next cycle, nor use MainBus then.
    function automatic bit exp_hazard(stim_t s);
        return !s.rst && !s.hold && !s.flush && s.op_valid && (m_wr[1] >= 0) &&
               ((s.lhs_en && int'(s.lhs_sel) == m_wr[1]) ||
                (s.rhs_en && int'(s.rhs_sel) == m_wr[1]) ||
                s.main_en);
    endfunction

    function automatic void model_step(stim_t s);
        bit rdy;
        rdy = !s.rst && !s.hold && !s.flush && !exp_hazard(s);
        if (s.rst || s.flush) begin
            model_clear();
        end else if (!s.hold) begin
            for (int k = 0; k < 2; k++) begin
                m_lhs[k] = m_lhs[k+1]; m_rhs[k] = m_rhs[k+1]; m_main[k] = m_main[k+1];
                m_load[k] = m_load[k+1]; m_oe[k] = m_oe[k+1]; m_wr[k] = m_wr[k+1];
            end
            m_lhs[2] = F; m_rhs[2] = F; m_main[2] = F; m_load[2] = F;
            m_oe[2] = 1'b0; m_wr[2] = -1;
            if (s.op_valid && rdy) begin
                m_lhs[0] = m_lhs[0] & strobe(s.lhs_en, int'(s.lhs_sel));
                m_rhs[0] = m_rhs[0] & strobe(s.rhs_en, int'(s.rhs_sel));
                if (s.main_en) begin
                    m_main[0] = m_main[0] & strobe(1'b1, int'(s.main_sel));
                    m_load[0] = m_load[0] & strobe(s.dst_en, int'(s.dst_sel));
                end else if (s.dst_en) begin
                    m_load[1] = m_load[1] & strobe(1'b1, int'(s.dst_sel));
                    m_oe[1]   = 1'b1;
                    m_wr[1]   = int'(s.dst_sel);
                end
            end
        end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic drive(stim_t s);
        rst          = s.rst;
        bus.op_valid = s.op_valid;
        bus.lhs_en   = s.lhs_en;
        bus.lhs_sel  = s.lhs_sel;
        bus.rhs_en   = s.rhs_en;
        bus.rhs_sel  = s.rhs_sel;
        bus.main_en  = s.main_en;
        bus.main_sel = s.main_sel;
        bus.dst_en   = s.dst_en;
        bus.dst_sel  = s.dst_sel;
        bus.hold     = s.hold;
        bus.flush    = s.flush;
    endtask

    task automatic cycle(vec_t v, bit use_tbl);
        bit          quiet;
        bit          haz;
        bit [NR-1:0] e_lhs, e_rhs, e_main, e_load;
        bit          e_oe;
        drive(v.s);
        @(negedge clk);
        quiet  = v.s.rst || v.s.hold;
        haz    = exp_hazard(v.s);
        e_lhs  = quiet ? F : m_lhs[0];
        e_rhs  = quiet ? F : m_rhs[0];
        e_main = quiet ? F : m_main[0];
        e_load = quiet ? F : m_load[0];
        e_oe   = !quiet && m_oe[0];
        chk("a_lhs_n",     32'(bus.a_lhs_n),     32'(e_lhs));
        chk("a_rhs_n",     32'(bus.a_rhs_n),     32'(e_rhs));
        chk("a_main_n",    32'(bus.a_main_n),    32'(e_main));
        chk("load_n",      32'(bus.load_n),      32'(e_load));
        chk("alu_main_oe", 32'(bus.alu_main_oe), 32'(e_oe));
        chk("hazard",      32'(bus.hazard),      32'(haz));
        chk("op_ready",    32'(bus.op_ready),
            32'(!v.s.rst && !v.s.hold && !v.s.flush && !haz));
        if (bus.load_n !== F) loads_seen++;
        if (use_tbl) begin
            chk("tbl_a_lhs_n",     32'(bus.a_lhs_n),     32'(v.lhs));
            chk("tbl_a_rhs_n",     32'(bus.a_rhs_n),     32'(v.rhs));
            chk("tbl_a_main_n",    32'(bus.a_main_n),    32'(v.main));
            chk("tbl_load_n",      32'(bus.load_n),      32'(v.load));
            chk("tbl_alu_main_oe", 32'(bus.alu_main_oe), 32'(v.oe));
            chk("tbl_hazard",      32'(bus.hazard),      32'(v.haz));
            chk("tbl_op_ready",    32'(bus.op_ready),    32'(v.rdy));
        end
        @(posedge clk);
        model_step(v.s);
        #1;
        cyc++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t op(bit le, int ls, bit re, int rs, bit me, int ms, bit de, int ds);
        stim_t s;
        s = idle();
        s.op_valid = 1'b1;
        s.lhs_en = le; s.lhs_sel = SW'(ls);
        s.rhs_en = re; s.rhs_sel = SW'(rs);
        s.main_en = me; s.main_sel = SW'(ms);
        s.dst_en = de; s.dst_sel = SW'(ds);
        return s;
    endfunction

    function automatic stim_t w_rst(stim_t s);   stim_t t = s; t.rst = 1'b1;   return t; endfunction
    function automatic stim_t w_hold(stim_t s);  stim_t t = s; t.hold = 1'b1;  return t; endfunction
    function automatic stim_t w_flush(stim_t s); stim_t t = s; t.flush = 1'b1; return t; endfunction

    function automatic vec_t row(stim_t s, bit [NR-1:0] l, bit [NR-1:0] r, bit [NR-1:0] m,
                                 bit [NR-1:0] ld, bit oe, bit haz, bit rdy);
        vec_t v;
        v.s = s; v.lhs = l; v.rhs = r; v.main = m; v.load = ld;
        v.oe = oe; v.haz = haz; v.rdy = rdy;
        return v;
    endfunction

    task automatic run(stim_t s);
        vec_t v;
        v = row(s, F, F, F, F, 1'b0, 1'b0, 1'b0);
        cycle(v, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t  tbl[$];
        stim_t alu_abc;
        stim_t s;
        n_chk = 0; n_pass = 0; cyc = 0; loads_seen = 0;
        model_clear();
        drive(w_rst(idle()));
        @(posedge clk);
        #1;

        alu_abc = op(1, A, 1, B, 0, 0, 1, C);
        // reset with op_valid held, then first acceptance
        tbl.push_back(row(w_rst(alu_abc), F, F, F, F, 0, 0, 0));
        tbl.push_back(row(w_rst(alu_abc), F, F, F, F, 0, 0, 0));
        tbl.push_back(row(alu_abc, F, F, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), 4'b1110, 4'b1101, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, F, 4'b1011, 1, 0, 1));
        // RAW hazard: read of C right behind an ALU write of C
        tbl.push_back(row(alu_abc, F, F, F, F, 0, 0, 1));
        tbl.push_back(row(op(1, C, 0, 0, 0, 0, 1, A), 4'b1110, 4'b1101, F, F, 0, 1, 0));
        tbl.push_back(row(op(1, C, 0, 0, 0, 0, 1, A), F, F, F, 4'b1011, 1, 0, 1));
        tbl.push_back(row(idle(), 4'b1011, F, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, F, 4'b1110, 1, 0, 1));
        // MainBus structural stall: ALU dst D then move B->A
        tbl.push_back(row(op(1, B, 1, C, 0, 0, 1, D), F, F, F, F, 0, 0, 1));
        tbl.push_back(row(op(0, 0, 0, 0, 1, B, 1, A), 4'b1101, 4'b1011, F, F, 0, 1, 0));
        tbl.push_back(row(op(0, 0, 0, 0, 1, B, 1, A), F, F, F, 4'b0111, 1, 0, 1));
        tbl.push_back(row(idle(), F, F, 4'b1101, 4'b1110, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));
        // hold for three cycles with the ALU op in S2
        tbl.push_back(row(alu_abc, F, F, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), 4'b1110, 4'b1101, F, F, 0, 0, 1));
        tbl.push_back(row(w_hold(idle()), F, F, F, F, 0, 0, 0));
        tbl.push_back(row(w_hold(idle()), F, F, F, F, 0, 0, 0));
        tbl.push_back(row(w_hold(idle()), F, F, F, F, 0, 0, 0));
        tbl.push_back(row(idle(), F, F, F, 4'b1011, 1, 0, 1));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));
        // flush with ops in S1 and S2; op offered with flush is refused
        tbl.push_back(row(alu_abc, F, F, F, F, 0, 0, 1));
        tbl.push_back(row(op(1, D, 0, 0, 0, 0, 1, B), 4'b1110, 4'b1101, F, F, 0, 0, 1));
        tbl.push_back(row(w_flush(op(0, 0, 0, 0, 1, D, 1, A)), 4'b0111, F, F, 4'b1011, 1, 0, 0));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));
        tbl.push_back(row(alu_abc, F, F, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), 4'b1110, 4'b1101, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, F, 4'b1011, 1, 0, 1));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));
        // reset mid-operation drops the pending write
        tbl.push_back(row(op(1, A, 0, 0, 0, 0, 1, C), F, F, F, F, 0, 0, 1));
        tbl.push_back(row(w_rst(idle()), F, F, F, F, 0, 0, 0));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));
        // compare-only op never stalls; C->C move is a legal reload
        tbl.push_back(row(op(1, C, 1, C, 0, 0, 0, 0), F, F, F, F, 0, 0, 1));
        tbl.push_back(row(op(0, 0, 0, 0, 1, C, 1, C), 4'b1011, 4'b1011, F, F, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, 4'b1011, 4'b1011, 0, 0, 1));
        tbl.push_back(row(idle(), F, F, F, F, 0, 0, 1));

        foreach (tbl[i]) cycle(tbl[i], 1'b1);

        // hold of random length around an S2 writeback: exactly one load pulse
        for (int n = 0; n < 3; n++) begin
            loads_seen = 0;
            run(op(1, A, 1, B, 0, 0, 1, n));
            run(idle());
            repeat ($urandom_range(1, 5)) run(w_hold(idle()));
            repeat (3) run(idle());
            chk("hold_load_pulses", 32'(loads_seen), 32'd1);
        end

        // flush with S1 and S2 occupied: no load afterwards, next op has normal latency
        run(op(1, A, 1, B, 0, 0, 1, D));
        run(op(1, C, 0, 0, 0, 0, 1, A));
        run(w_flush(idle()));
        loads_seen = 0;
        repeat (4) run(idle());
        chk("flush_no_load", 32'(loads_seen), 32'd0);
        run(op(1, B, 0, 0, 0, 0, 1, C));
        run(idle());
        run(idle());
        chk("post_flush_load", 32'(loads_seen), 32'd1);

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst      = ($urandom_range(0, 59) == 0);
            s.hold     = ($urandom_range(0, 9) == 0);
            s.flush    = ($urandom_range(0, 24) == 0);
            s.op_valid = ($urandom_range(0, 9) < 7);
            s.lhs_en   = 1'($urandom);
            s.lhs_sel  = SW'($urandom);
            s.rhs_en   = 1'($urandom);
            s.rhs_sel  = SW'($urandom);
            s.main_en  = ($urandom_range(0, 9) < 4);
            s.main_sel = SW'($urandom);
            s.dst_en   = ($urandom_range(0, 9) < 8);
            s.dst_sel  = SW'($urandom);
            run(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
